// File: rtl/column_fill.sv
// column_fill: expands one ray-hit record per screen column into SCREEN_HEIGHT pixel descriptors.
// Optional build macro COLUMN_FILL_FRAME_DONE_EN adds frame_done_out / frame_count_out.
module column_fill #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 180,
  parameter int TEX_SIZE      = 32,
  localparam int TB = $clog2(TEX_SIZE),
  localparam int AW = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  localparam int DW = 7 + 2*TB
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          col_in_tvalid,
  input  logic [37:0]   col_in_tdata,
  input  logic          col_in_tlast,
  output logic          col_in_tready,
  output logic          pix_tvalid,
  input  logic          pix_tready,
  output logic [AW-1:0] pix_addr_out,
  output logic [DW-1:0] pix_data_out,
  output logic          pix_tlast
`ifdef COLUMN_FILL_FRAME_DONE_EN
  ,
  output logic          frame_done_out,
  output logic [15:0]   frame_count_out
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_SETUP, S_EMIT} state_t;

  localparam logic [15:0]       DIVIDEND = 16'(TEX_SIZE << 8);
  localparam logic [7:0]        LAST_ROW = 8'(SCREEN_HEIGHT - 1);
  localparam logic [TB-1:0]     TEX_MAX  = TB'(TEX_SIZE - 1);
  localparam logic signed [9:0] HALF_S   = 10'(SCREEN_HEIGHT / 2);
  localparam logic signed [9:0] HEIGHT_S = 10'(SCREEN_HEIGHT);

  state_t state_q, state_d;
  logic [8:0]        hcount_q, hcount_d;
  logic [7:0]        lh_q, lh_d;
  logic              wt_q, wt_d;
  logic [3:0]        md_q, md_d;
  logic [TB-1:0]     texu_q, texu_d;
  logic              tlast_q, tlast_d;
  logic signed [9:0] start_q, start_d;
  logic [8:0]        ds_q, ds_d;
  logic [8:0]        de_q, de_d;
  logic [7:0]        rem_q, rem_d;
  logic [15:0]       quo_q, quo_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       step_q, step_d;
  logic [AW-1:0]     base_q, base_d;
  logic [23:0]       acc_q, acc_d;
  logic [7:0]        row_q, row_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              last_q, last_d;

  // Record decode
  logic [8:0]        rec_hcount;
  logic [7:0]        rec_lh;
  logic              rec_in_range;
  logic signed [9:0] start_c, end_c;
  logic [8:0]        ds_c, de_c;
  logic              unused_bits;

  assign rec_hcount   = col_in_tdata[37:29];
  assign rec_lh       = col_in_tdata[28:21];
  assign rec_in_range = {1'b0, rec_hcount} < 10'(SCREEN_WIDTH);
  assign start_c      = HALF_S - $signed({3'b000, rec_lh[7:1]});
  assign end_c        = start_c + $signed({2'b00, rec_lh});
  assign ds_c         = start_c[9] ? 9'd0 : start_c[8:0];
  assign de_c         = (end_c > HEIGHT_S) ? 9'(SCREEN_HEIGHT) : end_c[8:0];
  assign unused_bits  = ^col_in_tdata[15-TB:0];

  // Divider step and setup products
  logic [8:0]    trial;
  logic [15:0]   step_c;
  logic [9:0]    off_c;
  logic [AW-1:0] base_c;

  assign trial  = {rem_q, quo_q[15]};
  assign step_c = (lh_q == 8'd0) ? 16'd0 : quo_q;
  assign off_c  = {1'b0, ds_q} - start_q;
  assign base_c = AW'(32'(hcount_q) * SCREEN_HEIGHT);

  // Next descriptor: row 0 when priming, otherwise the row after the one in flight
  logic [7:0]    ld_row;
  logic [23:0]   ld_acc;
  logic [23:0]   acc_inc;
  logic [8:0]    row9_c;
  logic [1:0]    region_c;
  logic [15:0]   acc_hi_c;
  logic [TB-1:0] tv_c;
  logic          wall_c;
  logic [DW-1:0] desc_c;

  assign acc_inc  = (data_q[DW-1 -: 2] == 2'd1) ? {8'd0, step_q} : 24'd0;
  assign ld_row   = valid_q ? row_q + 8'd1 : row_q;
  assign ld_acc   = valid_q ? acc_q + acc_inc : acc_q;
  assign row9_c   = {1'b0, ld_row};
  assign region_c = (row9_c < ds_q) ? 2'd0 : (row9_c < de_q) ? 2'd1 : 2'd2;
  assign acc_hi_c = ld_acc[23:8];
  assign tv_c     = (acc_hi_c > 16'(TEX_SIZE - 1)) ? TEX_MAX : acc_hi_c[TB-1:0];
  assign wall_c   = (region_c == 2'd1);
  assign desc_c   = {region_c, md_q, wt_q,
                     wall_c ? texu_q : {TB{1'b0}},
                     wall_c ? tv_c   : {TB{1'b0}}};

  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    lh_d     = lh_q;
    wt_d     = wt_q;
    md_d     = md_q;
    texu_d   = texu_q;
    tlast_d  = tlast_q;
    start_d  = start_q;
    ds_d     = ds_q;
    de_d     = de_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    base_d   = base_q;
    acc_d    = acc_q;
    row_d    = row_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    last_d   = last_q;

    unique case (state_q)
      S_IDLE: begin
        // Out-of-range columns are swallowed here, tlast included
        if (col_in_tvalid && rec_in_range) begin
          hcount_d = rec_hcount;
          lh_d     = rec_lh;
          wt_d     = col_in_tdata[20];
          md_d     = col_in_tdata[19:16];
          texu_d   = col_in_tdata[15 -: TB];
          tlast_d  = col_in_tlast;
          start_d  = start_c;
          ds_d     = ds_c;
          de_d     = de_c;
          rem_d    = 8'd0;
          quo_d    = DIVIDEND;
          cnt_d    = 4'd0;
          state_d  = (rec_lh != 8'd0) ? S_DIVIDE : S_SETUP;
        end
      end
      S_DIVIDE: begin
        if (trial >= {1'b0, lh_q}) begin
          rem_d = 8'(trial - {1'b0, lh_q});
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = trial[7:0];
          quo_d = {quo_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_SETUP;
      end
      S_SETUP: begin
        step_d  = step_c;
        base_d  = base_c;
        acc_d   = {14'd0, off_c} * {8'd0, step_c};
        row_d   = 8'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (!valid_q || pix_tready) begin
          if (valid_q && row_q == LAST_ROW) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            row_d   = ld_row;
            acc_d   = ld_acc;
            valid_d = 1'b1;
            addr_d  = base_q + AW'(ld_row);
            data_d  = desc_c;
            last_d  = tlast_q && (ld_row == LAST_ROW);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      hcount_q <= '0;
      lh_q     <= '0;
      wt_q     <= 1'b0;
      md_q     <= '0;
      texu_q   <= '0;
      tlast_q  <= 1'b0;
      start_q  <= '0;
      ds_q     <= '0;
      de_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      lh_q     <= lh_d;
      wt_q     <= wt_d;
      md_q     <= md_d;
      texu_q   <= texu_d;
      tlast_q  <= tlast_d;
      start_q  <= start_d;
      ds_q     <= ds_d;
      de_q     <= de_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign col_in_tready = (state_q == S_IDLE);
  assign pix_tvalid    = valid_q;
  assign pix_addr_out  = addr_q;
  assign pix_data_out  = data_q;
  assign pix_tlast     = last_q;

`ifdef COLUMN_FILL_FRAME_DONE_EN
  logic        fd_q;
  logic [15:0] fc_q;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      fd_q <= 1'b0;
      fc_q <= 16'd0;
    end else begin
      fd_q <= valid_q && pix_tready && last_q;
      if (valid_q && pix_tready && last_q) fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_done_out  = fd_q;
  assign frame_count_out = fc_q;
`endif

endmodule

// File: tb/tb_column_fill.sv
// Directed bench for column_fill: column expansion, latency, backpressure, tlast, async reset.
`timescale 1ns/1ps
module tb_column_fill;
  localparam int H = 180;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        col_in_tvalid;
  logic [37:0] col_in_tdata;
  logic        col_in_tlast;
  logic        col_in_tready;
  logic        pix_tvalid;
  logic        pix_tready;
  logic [15:0] pix_addr_out;
  logic [16:0] pix_data_out;
  logic        pix_tlast;
`ifdef COLUMN_FILL_FRAME_DONE_EN
  logic        frame_done;
  logic [15:0] frame_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  column_fill dut (
    .pixel_clk_in (clk),
    .rst_in       (rst_in),
    .col_in_tvalid(col_in_tvalid),
    .col_in_tdata (col_in_tdata),
    .col_in_tlast (col_in_tlast),
    .col_in_tready(col_in_tready),
    .pix_tvalid   (pix_tvalid),
    .pix_tready   (pix_tready),
    .pix_addr_out (pix_addr_out),
    .pix_data_out (pix_data_out),
    .pix_tlast    (pix_tlast)
`ifdef COLUMN_FILL_FRAME_DONE_EN
    ,
    .frame_done_out (frame_done),
    .frame_count_out(frame_count)
`endif
  );

  // Expected descriptor from hand-computed column constants
  function automatic logic [16:0] exp_desc(int r, int ds, int de, int step, int acc0,
                                           logic [3:0] md, logic wt, logic [4:0] tu);
    int v;
    logic [1:0] rg;
    logic [4:0] tuo, tvo;
    tuo = 5'd0;
    tvo = 5'd0;
    if (r < ds) rg = 2'd0;
    else if (r < de) rg = 2'd1;
    else rg = 2'd2;
    if (rg == 2'd1) begin
      v = (acc0 + (r - ds) * step) / 256;
      if (v > 31) v = 31;
      tuo = tu;
      tvo = v[4:0];
    end
    return {rg, md, wt, tuo, tvo};
  endfunction

  // Called and returns at 1 time unit after a rising edge
  task automatic send_record(input int hc, input int lh, input logic wt, input logic [3:0] md,
                             input logic [15:0] wx, input logic last);
    int n;
    logic [8:0] hcv;
    logic [7:0] lhv;
    n = 0;
    hcv = hc[8:0];
    lhv = lh[7:0];
    while (!col_in_tready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    col_in_tdata  = {hcv, lhv, wt, md, wx};
    col_in_tlast  = last;
    col_in_tvalid = 1'b1;
    @(posedge clk); #1;
    col_in_tvalid = 1'b0;
    col_in_tlast  = 1'b0;
  endtask

  task automatic recv_pixel(output logic [15:0] a, output logic [16:0] d, output logic l,
                            output int cyc);
    pix_tready = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!pix_tvalid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    a = pix_addr_out;
    d = pix_data_out;
    l = pix_tlast;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    col_in_tvalid = 1'b0;
    col_in_tdata = '0;
    col_in_tlast = 1'b0;
    pix_tready = 1'b1;
    #12;
    tests++;
    if (pix_tvalid !== 1'b0 || pix_tlast !== 1'b0) begin
      fails++; $display("FAIL reset_flags: valid=%b last=%b expected 0 0", pix_tvalid, pix_tlast);
    end
    tests++;
    if (pix_addr_out !== 16'd0 || pix_data_out !== 17'd0) begin
      fails++; $display("FAIL reset_bus: addr=%0d data=%h expected 0 0", pix_addr_out, pix_data_out);
    end
    #10 rst_in = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (col_in_tready !== 1'b1) begin
      fails++; $display("FAIL reset_tready: got %b expected 1", col_in_tready);
    end
  endtask

  task automatic test_lh60();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(5, 60, 1'b1, 4'hA, 16'hF800, 1'b0);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 18 : 1)) begin
        fails++; $display("FAIL lh60_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 18 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 60, 120, 136, 0, 4'hA, 1'b1, 5'd31);
      tests++;
      if (a !== 16'(900 + r)) begin
        fails++; $display("FAIL lh60_addr row %0d: got %0d expected %0d", r, a, 900 + r);
      end
      tests++;
      if (d !== e) begin
        fails++; $display("FAIL lh60_data row %0d: got %h expected %h", r, d, e);
      end
      tests++;
      if (l !== 1'b0) begin
        fails++; $display("FAIL lh60_tlast row %0d: got %b expected 0", r, l);
      end
      if (r == 60 || r == 119) begin
        tests++;
        if (d[4:0] !== ((r == 60) ? 5'd0 : 5'd31)) begin
          fails++; $display("FAIL lh60_texv_anchor row %0d: got %0d", r, d[4:0]);
        end
      end
    end
    @(posedge clk); #1;
    tests++;
    if (pix_tvalid !== 1'b0 || col_in_tready !== 1'b1) begin
      fails++; $display("FAIL lh60_end: valid=%b tready=%b expected 0 1", pix_tvalid, col_in_tready);
    end
  endtask

  task automatic test_lh255();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(0, 255, 1'b0, 4'h3, 16'h2400, 1'b0);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 18 : 1)) begin
        fails++; $display("FAIL lh255_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 18 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 0, 180, 32, 1184, 4'h3, 1'b0, 5'd4);
      tests++;
      if (a !== 16'(r)) begin
        fails++; $display("FAIL lh255_addr row %0d: got %0d expected %0d", r, a, r);
      end
      tests++;
      if (d !== e) begin
        fails++; $display("FAIL lh255_data row %0d: got %h expected %h", r, d, e);
      end
      if (r == 0) begin
        tests++;
        if (d[4:0] !== 5'd4) begin
          fails++; $display("FAIL lh255_texv_row0: got %0d expected 4", d[4:0]);
        end
      end
    end
  endtask

  task automatic test_lh0();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(1, 0, 1'b1, 4'h5, 16'hFFFF, 1'b0);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 2 : 1)) begin
        fails++; $display("FAIL lh0_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 2 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 90, 90, 0, 0, 4'h5, 1'b1, 5'd31);
      tests++;
      if (a !== 16'(180 + r)) begin
        fails++; $display("FAIL lh0_addr row %0d: got %0d expected %0d", r, a, 180 + r);
      end
      tests++;
      if (d !== e) begin
        fails++; $display("FAIL lh0_data row %0d: got %h expected %h", r, d, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(2, 60, 1'b0, 4'h7, 16'h8000, 1'b0);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 18 : 1)) begin
        fails++; $display("FAIL bp_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 18 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 60, 120, 136, 0, 4'h7, 1'b0, 5'd16);
      tests++;
      if (a !== 16'(360 + r) || d !== e) begin
        fails++; $display("FAIL bp_pixel row %0d: got addr %0d data %h expected %0d %h", r, a, d, 360 + r, e);
      end
      if (r == 10) begin
        pix_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          tests++;
          if (pix_tvalid !== 1'b1 || pix_addr_out !== a || pix_data_out !== d) begin
            fails++; $display("FAIL bp_hold stall %0d: valid=%b addr=%0d data=%h expected 1 %0d %h",
                              s, pix_tvalid, pix_addr_out, pix_data_out, a, d);
          end
          tests++;
          if (col_in_tready !== 1'b0) begin
            fails++; $display("FAIL bp_col_tready stall %0d: got %b expected 0", s, col_in_tready);
          end
        end
      end
    end
  endtask

  task automatic test_invalid_hcount();
    int seen;
    send_record(320, 60, 1'b1, 4'h1, 16'hF800, 1'b1);
    tests++;
    if (col_in_tready !== 1'b1) begin
      fails++; $display("FAIL badcol_tready: got %b expected 1", col_in_tready);
    end
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (pix_tvalid === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL badcol_output: got %0d valid cycles expected 0", seen);
    end
`ifdef COLUMN_FILL_FRAME_DONE_EN
    tests++;
    if (frame_count !== 16'd0) begin
      fails++; $display("FAIL badcol_frame_count: got %0d expected 0", frame_count);
    end
`endif
  endtask

  task automatic test_tlast();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(319, 100, 1'b1, 4'hC, 16'h1000, 1'b1);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 18 : 1)) begin
        fails++; $display("FAIL tlast_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 18 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 40, 140, 81, 0, 4'hC, 1'b1, 5'd2);
      tests++;
      if (a !== 16'(57420 + r) || d !== e) begin
        fails++; $display("FAIL tlast_pixel row %0d: got addr %0d data %h expected %0d %h", r, a, d, 57420 + r, e);
      end
      tests++;
      if (l !== (r == H - 1)) begin
        fails++; $display("FAIL tlast_flag row %0d: got %b expected %b", r, l, r == H - 1);
      end
`ifdef COLUMN_FILL_FRAME_DONE_EN
      tests++;
      if (frame_done !== 1'b0 || frame_count !== 16'd0) begin
        fails++; $display("FAIL frame_done_early row %0d: pulse=%b count=%0d expected 0 0", r, frame_done, frame_count);
      end
`endif
    end
    @(posedge clk); #1;
    tests++;
    if (pix_tvalid !== 1'b0 || pix_tlast !== 1'b0) begin
      fails++; $display("FAIL tlast_end: valid=%b last=%b expected 0 0", pix_tvalid, pix_tlast);
    end
`ifdef COLUMN_FILL_FRAME_DONE_EN
    tests++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1) begin
      fails++; $display("FAIL frame_done_pulse: pulse=%b count=%0d expected 1 1", frame_done, frame_count);
    end
    @(posedge clk); #1;
    tests++;
    if (frame_done !== 1'b0 || frame_count !== 16'd1) begin
      fails++; $display("FAIL frame_done_clear: pulse=%b count=%0d expected 0 1", frame_done, frame_count);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [15:0] a; logic [16:0] d, e; logic l; int cyc;
    send_record(3, 60, 1'b1, 4'h2, 16'hF800, 1'b1);
    for (int r = 0; r <= 50; r++) begin
      recv_pixel(a, d, l, cyc);
      if (cyc >= 100) break;
    end
    tests++;
    if (a !== 16'(540 + 50)) begin
      fails++; $display("FAIL areset_pre_addr: got %0d expected 590", a);
    end
    #2 rst_in = 1'b1;
    #1;
    tests++;
    if (pix_tvalid !== 1'b0 || pix_addr_out !== 16'd0 || pix_data_out !== 17'd0) begin
      fails++; $display("FAIL areset_immediate: valid=%b addr=%0d data=%h expected 0 0 0",
                        pix_tvalid, pix_addr_out, pix_data_out);
    end
    @(posedge clk);
    #3 rst_in = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (col_in_tready !== 1'b1 || pix_tvalid !== 1'b0) begin
      fails++; $display("FAIL areset_idle: tready=%b valid=%b expected 1 0", col_in_tready, pix_tvalid);
    end
    send_record(4, 60, 1'b1, 4'h9, 16'hF800, 1'b0);
    for (int r = 0; r < H; r++) begin
      recv_pixel(a, d, l, cyc);
      tests++;
      if (cyc !== ((r == 0) ? 18 : 1)) begin
        fails++; $display("FAIL areset_timing row %0d: got %0d cycles expected %0d", r, cyc, (r == 0) ? 18 : 1);
      end
      if (cyc >= 100) break;
      e = exp_desc(r, 60, 120, 136, 0, 4'h9, 1'b1, 5'd31);
      tests++;
      if (a !== 16'(720 + r) || d !== e || l !== 1'b0) begin
        fails++; $display("FAIL areset_pixel row %0d: got addr %0d data %h last %b expected %0d %h 0",
                          r, a, d, l, 720 + r, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lh60();
    test_lh255();
    test_lh0();
    test_backpressure();
    test_invalid_hcount();
    test_tlast();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
